imm_extend_pipe: RTL and testbench

IMM_EXTEND_PIPE -- requirements
Module: imm_extend_pipe

---
 rtl/imm_extend_pipe.sv | 170 +++++++++++++++++
 tb/tb_imm_extend_pipe.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/imm_extend_pipe.sv
// ---------------------------------------------------------------------------
// imm_extend_pipe
//   Immediate-extension unit with a 2-entry output FIFO. The extension mode
//   selects how the instruction fields are widened to DATA_W bits. The result,
//   the caller's tag and an illegal-mode flag are computed combinationally at
//   the input and stored in a small skid FIFO. There is no combinational path
//   from the input side to the output side.
//
// Parameters
//   DATA_W      output immediate width (32 or greater)
//   TAG_W       sideband tag width
//
// Ports
//   clk         clock, rising edge
//   resetn      synchronous active-low reset
//   in_valid    request present
//   in_ready    request accepted this cycle when in_valid is also 1
//   ext_sel     extension mode
//                 000 sext(imm16)
//                 001 zext(imm16)
//                 010 zext(shamt)
//                 011 LUI
//                 100 branch offset
//                 101 jump target
//                 11x illegal
//   shamt       shift amount field
//   imm16       16-bit immediate field
//   idx26       jump instr_index field
//   in_tag      sideband carried with the operand
//   out_valid   FIFO head valid
//   out_ready   consumer accepts the head this cycle
//   out_imm     extended immediate at the FIFO head
//   out_tag     tag at the FIFO head
//   out_illegal head was produced by an illegal mode
//   flush       discard all buffered entries
// ---------------------------------------------------------------------------
module imm_extend_pipe #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        ext_sel,
  input  logic [4:0]        shamt,
  input  logic [15:0]       imm16,
  input  logic [25:0]       idx26,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_imm,
  output logic [TAG_W-1:0]  out_tag,
  output logic              out_illegal,
  input  logic              flush
);

  // Sized casts of signed operands sign-extend; casts of unsigned operands
  // zero-extend.
  function automatic logic signed [DATA_W-1:0] extend_imm(
    input logic [2:0]  sel,
    input logic [4:0]  sh,
    input logic [15:0] imm,
    input logic [25:0] idx
  );
    logic signed [DATA_W-1:0] s;
    s = DATA_W'(signed'(imm));
    case (sel)
      3'b000:  extend_imm = s;
      3'b001:  extend_imm = DATA_W'(imm);
      3'b010:  extend_imm = DATA_W'(sh);
      3'b011:  extend_imm = DATA_W'(signed'({imm, 16'h0000}));
      3'b100:  extend_imm = s <<< 2;
      3'b101:  extend_imm = DATA_W'({idx, 2'b00});
      default: extend_imm = '0;
    endcase
  endfunction

  logic signed [DATA_W-1:0] w_ext_imm;
  logic                     w_ext_ill;
  logic                     w_push;
  logic                     w_pop;
  logic [1:0]               w_count_nx;
  logic                     w_wr_nx;
  logic                     w_rd_nx;
  logic                     w_wr_hit;

  logic [1:0]               r_count;
  logic                     r_wr_ptr;
  logic                     r_rd_ptr;
  logic signed [DATA_W-1:0] r_imm [2];
  logic [TAG_W-1:0]         r_tag [2];
  logic                     r_ill [2];
  logic signed [DATA_W-1:0] r_out_imm;
  logic [TAG_W-1:0]         r_out_tag;
  logic                     r_out_ill;

  assign w_ext_imm = extend_imm(ext_sel, shamt, imm16, idx26);
  assign w_ext_ill = ext_sel[2] & ext_sel[1];

  assign in_ready  = resetn & (r_count != 2'd2);
  assign out_valid = (r_count != 2'd0);
  assign w_push    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;

  always_comb begin
    w_count_nx = r_count;
    w_wr_nx    = r_wr_ptr;
    w_rd_nx    = r_rd_ptr;
    if (flush) begin
      w_count_nx = 2'd0;
      w_wr_nx    = 1'b0;
      w_rd_nx    = 1'b0;
    end else begin
      if (w_push) w_wr_nx = ~r_wr_ptr;
      if (w_pop)  w_rd_nx = ~r_rd_ptr;
      w_count_nx = r_count + 2'(w_push) - 2'(w_pop);
    end
  end

  // The head after this edge is the entry being written right now when the
  // write slot and the next read slot coincide (push into empty, or push+pop
  // at count 1).
  assign w_wr_hit = w_push & (r_wr_ptr == w_rd_nx);

  // ---- FIFO storage and registered head ----
  // The head copy is reloaded only while the FIFO stays non-empty, so the
  // outputs keep their last values once it drains or is flushed.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_count   <= 2'd0;
      r_wr_ptr  <= 1'b0;
      r_rd_ptr  <= 1'b0;
      r_imm[0]  <= '0;
      r_imm[1]  <= '0;
      r_tag[0]  <= '0;
      r_tag[1]  <= '0;
      r_ill[0]  <= 1'b0;
      r_ill[1]  <= 1'b0;
      r_out_imm <= '0;
      r_out_tag <= '0;
      r_out_ill <= 1'b0;
    end else begin
      r_count  <= w_count_nx;
      r_wr_ptr <= w_wr_nx;
      r_rd_ptr <= w_rd_nx;
      if (w_push && !flush) begin
        r_imm[r_wr_ptr] <= w_ext_imm;
        r_tag[r_wr_ptr] <= in_tag;
        r_ill[r_wr_ptr] <= w_ext_ill;
      end
      if (!flush && (w_count_nx != 2'd0)) begin
        if (w_wr_hit) begin
          r_out_imm <= w_ext_imm;
          r_out_tag <= in_tag;
          r_out_ill <= w_ext_ill;
        end else begin
          r_out_imm <= r_imm[w_rd_nx];
          r_out_tag <= r_tag[w_rd_nx];
          r_out_ill <= r_ill[w_rd_nx];
        end
      end
    end
  end

  assign out_imm     = r_out_imm;
  assign out_tag     = r_out_tag;
  assign out_illegal = r_out_ill;

endmodule

// File: tb/tb_imm_extend_pipe.sv
module tb_imm_extend_pipe;

  logic        clk;
  logic        resetn;
  logic        in_valid;
  logic [2:0]  ext_sel;
  logic [4:0]  shamt;
  logic [15:0] imm16;
  logic [25:0] idx26;
  logic [7:0]  in_tag;
  logic        out_ready;
  logic        flush;

  logic        in_ready,  in_ready64;
  logic        out_valid, out_valid64;
  logic [31:0] out_imm;
  logic [63:0] out_imm64;
  logic [7:0]  out_tag,   out_tag64;
  logic        out_illegal, out_illegal64;

  int n_checks = 0;
  int n_fail   = 0;

  imm_extend_pipe #(.DATA_W(32), .TAG_W(8)) dut32 (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
    .ext_sel(ext_sel), .shamt(shamt), .imm16(imm16), .idx26(idx26),
    .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .out_imm(out_imm), .out_tag(out_tag), .out_illegal(out_illegal),
    .flush(flush)
  );

  imm_extend_pipe #(.DATA_W(64), .TAG_W(8)) dut64 (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready64),
    .ext_sel(ext_sel), .shamt(shamt), .imm16(imm16), .idx26(idx26),
    .in_tag(in_tag), .out_valid(out_valid64), .out_ready(out_ready),
    .out_imm(out_imm64), .out_tag(out_tag64), .out_illegal(out_illegal64),
    .flush(flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0; in_valid = 1'b1; in_tag = 8'h77;
    tick(); tick();
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready got %0b want 0", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got %0b want 0", out_valid); end
    n_checks++; if (out_imm !== 32'h0) begin n_fail++; $display("FAIL rst_out_imm got %h want 0", out_imm); end
    n_checks++; if (out_tag !== 8'h0) begin n_fail++; $display("FAIL rst_out_tag got %h want 0", out_tag); end
    n_checks++; if (out_illegal !== 1'b0) begin n_fail++; $display("FAIL rst_out_illegal got %0b want 0", out_illegal); end
    resetn = 1'b1; in_valid = 1'b0;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_in_ready got %0b want 1", in_ready); end
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_release_out_valid got %0b want 0", out_valid); end
  endtask

  task automatic test_sext();
    out_ready = 1'b0;
    in_valid = 1'b1; ext_sel = 3'b000; imm16 = 16'h8000; in_tag = 8'h05;
    tick();
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL sext_valid got %0b want 1", out_valid); end
    n_checks++; if (out_imm !== 32'hFFFF8000) begin n_fail++; $display("FAIL sext_imm32 got %h want FFFF8000", out_imm); end
    n_checks++; if (out_imm64 !== 64'hFFFFFFFFFFFF8000) begin n_fail++; $display("FAIL sext_imm64 got %h want FFFFFFFFFFFF8000", out_imm64); end
    n_checks++; if (out_illegal !== 1'b0) begin n_fail++; $display("FAIL sext_illegal got %0b want 0", out_illegal); end
    tick();
    n_checks++; if (out_imm !== 32'hFFFF8000) begin n_fail++; $display("FAIL sext_stall_hold got %h want FFFF8000", out_imm); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL sext_drain_valid got %0b want 0", out_valid); end
    n_checks++; if (out_imm !== 32'hFFFF8000) begin n_fail++; $display("FAIL sext_empty_hold got %h want FFFF8000", out_imm); end
  endtask

  task automatic test_modes();
    logic [2:0]  t_sel [8] = '{3'b011, 3'b100, 3'b101, 3'b001, 3'b010, 3'b100, 3'b110, 3'b111};
    logic [15:0] t_imm [8] = '{16'h8001, 16'hFFFF, 16'h0000, 16'h8000, 16'hFFFF, 16'h4000, 16'h1234, 16'hFFFF};
    logic [4:0]  t_sh  [8] = '{5'd3, 5'd0, 5'd0, 5'd9, 5'd31, 5'd0, 5'd7, 5'd31};
    logic [25:0] t_idx [8] = '{26'h1, 26'h0, 26'h3FFFFFF, 26'h0, 26'h0, 26'h0, 26'h3FFFFFF, 26'h1};
    logic [31:0] e32   [8] = '{32'h80010000, 32'hFFFFFFFC, 32'h0FFFFFFC, 32'h00008000,
                               32'h0000001F, 32'h00010000, 32'h0, 32'h0};
    logic [63:0] e64   [8] = '{64'hFFFFFFFF80010000, 64'hFFFFFFFFFFFFFFFC, 64'h000000000FFFFFFC,
                               64'h0000000000008000, 64'h000000000000001F, 64'h0000000000010000,
                               64'h0, 64'h0};
    logic        e_ill [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [7:0]  t_tag [8] = '{8'h40, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'hAA, 8'h47};
    for (int i = 0; i < 8; i++) begin
      out_ready = 1'b0;
      in_valid = 1'b1; ext_sel = t_sel[i]; imm16 = t_imm[i]; shamt = t_sh[i];
      idx26 = t_idx[i]; in_tag = t_tag[i];
      tick();
      in_valid = 1'b0;
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL mode%0d_valid got %0b want 1", i, out_valid); end
      n_checks++; if (out_imm !== e32[i]) begin n_fail++; $display("FAIL mode%0d_imm32 got %h want %h", i, out_imm, e32[i]); end
      n_checks++; if (out_imm64 !== e64[i]) begin n_fail++; $display("FAIL mode%0d_imm64 got %h want %h", i, out_imm64, e64[i]); end
      n_checks++; if (out_illegal !== e_ill[i]) begin n_fail++; $display("FAIL mode%0d_illegal got %0b want %0b", i, out_illegal, e_ill[i]); end
      n_checks++; if (out_illegal64 !== e_ill[i]) begin n_fail++; $display("FAIL mode%0d_illegal64 got %0b want %0b", i, out_illegal64, e_ill[i]); end
      n_checks++; if (out_tag !== t_tag[i]) begin n_fail++; $display("FAIL mode%0d_tag got %h want %h", i, out_tag, t_tag[i]); end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0; ext_sel = 3'b000; imm16 = 16'h0001;
    in_valid = 1'b1; in_tag = 8'd1;
    tick();
    in_tag = 8'd2;
    tick();
    in_tag = 8'd3;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full_in_ready got %0b want 0", in_ready); end
    tick();
    n_checks++; if (out_tag !== 8'd1) begin n_fail++; $display("FAIL bp_hold_tag got %0d want 1", out_tag); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_still_full got %0b want 0", in_ready); end
    out_ready = 1'b1;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_no_refill got %0b want 0", in_ready); end
    tick();
    n_checks++; if (out_tag !== 8'd2) begin n_fail++; $display("FAIL bp_pop1_tag got %0d want 2", out_tag); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_back got %0b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    n_checks++; if (out_tag !== 8'd3) begin n_fail++; $display("FAIL bp_tag3 got %0d want 3", out_tag); end
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_tag3_valid got %0b want 1", out_valid); end
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drained got %0b want 0", out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1; ext_sel = 3'b001;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_tag = 8'(10 + i); imm16 = 16'(16'h0100 + i);
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b%0d_in_ready got %0b want 1", i, in_ready); end
      tick();
      n_checks++; if (out_tag !== 8'(10 + i)) begin n_fail++; $display("FAIL b2b%0d_tag got %0d want %0d", i, out_tag, 10 + i); end
      n_checks++; if (out_imm !== 32'(32'h0100 + i)) begin n_fail++; $display("FAIL b2b%0d_imm got %h want %h", i, out_imm, 32'h0100 + i); end
    end
    in_valid = 1'b0;
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain got %0b want 0", out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_flush();
    out_ready = 1'b0; ext_sel = 3'b000; imm16 = 16'h0020;
    in_valid = 1'b1; in_tag = 8'd20;
    tick();
    in_tag = 8'd21;
    tick();
    flush = 1'b1; in_tag = 8'd22;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid got %0b want 0", out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_in_ready got %0b want 1", in_ready); end
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_no_store got %0b want 0", out_valid); end
    in_valid = 1'b1; in_tag = 8'd23;
    tick();
    in_valid = 1'b0;
    n_checks++; if (out_tag !== 8'd23) begin n_fail++; $display("FAIL flush_after_tag got %0d want 23", out_tag); end
    out_ready = 1'b1;
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_after_single got %0b want 0", out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0; ext_sel = 3'b000; imm16 = 16'h1234;
    in_valid = 1'b1; in_tag = 8'd30;
    tick();
    n_checks++; if (out_imm !== 32'h00001234) begin n_fail++; $display("FAIL rmid_pre_imm got %h want 00001234", out_imm); end
    resetn = 1'b0; in_tag = 8'd31;
    #1;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rmid_in_ready got %0b want 0", in_ready); end
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid got %0b want 0", out_valid); end
    n_checks++; if (out_imm !== 32'h0) begin n_fail++; $display("FAIL rmid_imm got %h want 0", out_imm); end
    n_checks++; if (out_tag !== 8'h0) begin n_fail++; $display("FAIL rmid_tag got %h want 0", out_tag); end
    resetn = 1'b1; in_valid = 1'b0;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_release_ready got %0b want 1", in_ready); end
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_ignored_push got %0b want 0", out_valid); end
  endtask

  initial begin
    resetn = 1'b0; in_valid = 1'b0; ext_sel = 3'b000; shamt = 5'd0;
    imm16 = 16'h0; idx26 = 26'h0; in_tag = 8'h0; out_ready = 1'b0; flush = 1'b0;
    tick();
    test_reset();
    test_sext();
    test_modes();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
